// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// 27 MHz divisor table also used by the baud-rate stage.
package uart_pkg;

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam int unsigned MIN_DIV   = 8;

  // Clocks per bit at 27 MHz
  localparam logic [DIV_W-1:0] DIV_9600   = 16'd2812;
  localparam logic [DIV_W-1:0] DIV_38400  = 16'd703;
  localparam logic [DIV_W-1:0] DIV_115200 = 16'd234;
  localparam logic [DIV_W-1:0] DIV_230400 = 16'd117;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rxd metastability synchronizer plus registered falling-edge (start) detector.
// Edges are only reported once a genuine high has been seen since reset.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_sync,
  output logic start_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   edge_q, edge_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // fill_q marks when the chain holds real pin samples rather than reset ones
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rxd};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    prev_d  = synced;
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & synced);
    edge_d  = armed_q & prev_q & ~synced;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      fill_q  <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      edge_q  <= edge_d;
    end
  end

  assign rxd_sync   = synced;
  assign start_edge = edge_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling FSM driven by a divisor latched at the
// start edge; emits one-cycle valid / framing-error strobes.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     bps_cnt_data,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  rx_state_e               state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]    bit_q, bit_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [DATA_BITS-1:0]    rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_frame_err_q, rx_frame_err_d;
  logic                    rx_busy_q, rx_busy_d;
  logic                    rxd_s;
  logic                    start_edge;
  logic [DIV_W-1:0]        half_div;
  logic [DIV_W-1:0]        last_cnt;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rxd_sync  (rxd_s),
    .start_edge(start_edge)
  );

  assign half_div = div_q >> 1;
  assign last_cnt = div_q - DIV_W'(1);

  // In START the counter holds cycles elapsed since the start-edge cycle
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    cnt_d          = cnt_q + DIV_W'(1);
    bit_d          = bit_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) begin
          div_d = bps_cnt_data;
          cnt_d = DIV_W'(1);
          bit_d = '0;
          if (bps_cnt_data >= DIV_W'(MIN_DIV)) begin
            state_d = START;
          end
        end
      end
      START: begin
        if (cnt_q == half_div) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == last_cnt) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_IDX_W'(1);
          if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed
        if (cnt_q == last_cnt) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxd_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      div_q          <= '0;
      cnt_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule
